mem_port_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single BRAM adapter port between the instruction-fetch unit (IFU) and the load/store unit (LSU). It accepts requests with a valid/grant handshake, registers the winning request, and drives the adapter's `en`/`we`/`addr`/`din`/`mask` inputs stable for the whole access. It waits for the adapter's `done`, then returns read data and a completion pulse to the owning requester. A watchdog converts a hung access into an error response.

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/mem_arb_watchdog.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the IFU/LSU memory-port arbiter:
//   arb_state_e : sequencer states (IDLE, ISSUE, WAIT, FLUSH)
//   owner_e     : which requester owns the access in flight
//   mem_req_t   : the registered request driven onto the adapter port
//   wd_width()  : watchdog counter width for a given timeout
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e              owner;
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   din;
        logic [MASK_W-1:0]   mask;
    } mem_req_t;

    function automatic int wd_width(input int timeout_cycles);
        return $clog2(timeout_cycles);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// -----------------------------------------------------------------------------
// mem_arb_watchdog
// Counts cycles spent waiting for the adapter and flags expiry once the count
// reaches TIMEOUT_CYCLES-1. The count saturates at that value.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : restart the count at zero (has priority over i_enable)
//   i_enable    : advance the count by one this cycle
//   o_expire    : count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int                WD_W  = wd_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]   LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_count;

    // NOTE: clocked state is always written with <= so every flop samples
    // the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one BRAM adapter port between the instruction-fetch unit (read only)
// and the load/store unit. A request is accepted in IDLE on req & gnt, the
// winning fields are registered onto the mem_* outputs, mem_en_o is pulsed in
// ISSUE, and the arbiter waits for mem_done_i. Completion is returned to the
// owner as a registered done pulse (plus read data on reads). A watchdog turns
// a hung access into a done+err pulse, after which FLUSH waits for the adapter
// to go idle.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   ifu_req_i/ifu_addr_i            : IFU read request
//   ifu_gnt_o/done_o/err_o/rdata_o  : IFU grant, completion, error, read data
//   lsu_req_i/we_i/addr_i/wdata_i/mask_i : LSU request
//   lsu_gnt_o/done_o/err_o/rdata_o  : LSU grant, completion, error, read data
//   mem_en_o/we_o/addr_o/din_o/mask_o : adapter request
//   mem_dout_i/busy_i/done_i        : adapter response
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit RR_EN          = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifu_req_i,
    input  logic [ADDR_W-1:0] ifu_addr_i,
    output logic              ifu_gnt_o,
    output logic              ifu_done_o,
    output logic              ifu_err_o,
    output logic [DATA_W-1:0] ifu_rdata_o,

    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic [MASK_W-1:0] lsu_mask_i,
    output logic              lsu_gnt_o,
    output logic              lsu_done_o,
    output logic              lsu_err_o,
    output logic [DATA_W-1:0] lsu_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    output logic [MASK_W-1:0] mem_mask_o,
    input  logic [DATA_W-1:0] mem_dout_i,
    input  logic              mem_busy_i,
    input  logic              mem_done_i
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    owner_e            r_last;
    mem_req_t          r_req;
    mem_req_t          w_req_sel;

    logic              w_idle;
    logic              w_pick_lsu;
    logic              w_accept;
    logic              w_complete;
    logic              w_timeout;
    logic              w_wd_clear;
    logic              w_wd_enable;
    logic              w_wd_expire;

    logic              r_ifu_done;
    logic              r_ifu_err;
    logic [DATA_W-1:0] r_ifu_rdata;
    logic              r_lsu_done;
    logic              r_lsu_err;
    logic [DATA_W-1:0] r_lsu_rdata;

    // ---------------------------------------------------------------- arbiter
    // The LSU wins when it is alone, when fixed priority is selected, or when
    // the IFU was the last port served.
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_pick_lsu = lsu_req_i && (!ifu_req_i || !RR_EN || (r_last == OWN_IFU));
        w_accept   = w_idle && (ifu_req_i || lsu_req_i);

        w_req_sel = '0;
        if (w_pick_lsu) begin
            w_req_sel.owner = OWN_LSU;
            w_req_sel.we    = lsu_we_i;
            w_req_sel.addr  = lsu_addr_i;
            w_req_sel.din   = lsu_wdata_i;
            w_req_sel.mask  = lsu_we_i ? lsu_mask_i : '0;
        end else begin
            w_req_sel.owner = OWN_IFU;
            w_req_sel.addr  = ifu_addr_i;
        end
    end

    // Grants are combinational; gating with rst_n keeps them low while the
    // block is held in reset.
    assign ifu_gnt_o = rst_n && w_idle && ifu_req_i && !w_pick_lsu;
    assign lsu_gnt_o = rst_n && w_idle && w_pick_lsu;

    // -------------------------------------------------------------- sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Only leaves once the enable has actually been presented.
                if (!mem_busy_i) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // done has priority over a watchdog expiring the same cycle.
                if (mem_done_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_wd_expire) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!mem_busy_i && !mem_done_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wd_clear  = (r_state == ST_ISSUE);
    assign w_wd_enable = (r_state == ST_WAIT) && !mem_done_i;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_wd_expire)
    );

    // --------------------------------------------------------------- datapath
    // r_req is only reloaded on accept, so the adapter inputs stay stable
    // through the adapter's whole access including its DONE phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req       <= '0;
            r_last      <= OWN_IFU;
            r_ifu_done  <= 1'b0;
            r_ifu_err   <= 1'b0;
            r_ifu_rdata <= '0;
            r_lsu_done  <= 1'b0;
            r_lsu_err   <= 1'b0;
            r_lsu_rdata <= '0;
        end else begin
            if (w_accept) r_req <= w_req_sel;

            r_ifu_done <= (w_complete || w_timeout) && (r_req.owner == OWN_IFU);
            r_lsu_done <= (w_complete || w_timeout) && (r_req.owner == OWN_LSU);
            r_ifu_err  <= w_timeout && (r_req.owner == OWN_IFU);
            r_lsu_err  <= w_timeout && (r_req.owner == OWN_LSU);

            if (w_complete) begin
                r_last <= r_req.owner;
                if (!r_req.we) begin
                    if (r_req.owner == OWN_LSU) r_lsu_rdata <= mem_dout_i;
                    else                        r_ifu_rdata <= mem_dout_i;
                end
            end else if (w_timeout) begin
                if (r_req.owner == OWN_LSU) r_lsu_rdata <= '0;
                else                        r_ifu_rdata <= '0;
            end
        end
    end

    assign ifu_done_o  = r_ifu_done;
    assign ifu_err_o   = r_ifu_err;
    assign ifu_rdata_o = r_ifu_rdata;
    assign lsu_done_o  = r_lsu_done;
    assign lsu_err_o   = r_lsu_err;
    assign lsu_rdata_o = r_lsu_rdata;

    assign mem_en_o   = (r_state == ST_ISSUE) && !mem_busy_i;
    assign mem_we_o   = r_req.we;
    assign mem_addr_o = r_req.addr;
    assign mem_din_o  = r_req.din;
    assign mem_mask_o = r_req.mask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiters share the requester inputs: dut0 (round-robin) talks to a
// word-array adapter model with programmable latency / hang, dut1 (fixed LSU
// priority) to a fixed 4-cycle adapter. Expected data comes from a reference
// memory array and the request-to-done latency rule (adapter latency + 2).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        ifu_req, lsu_req, lsu_we;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
    logic [3:0]  lsu_mask;

    logic        ifu_gnt, ifu_done, ifu_err, lsu_gnt, lsu_done, lsu_err;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic        mem_en, mem_we, mem_busy, mem_done;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [3:0]  mem_mask;

    logic        ifu_gnt1, ifu_done1, ifu_err1, lsu_gnt1, lsu_done1, lsu_err1;
    logic [31:0] ifu_rdata1, lsu_rdata1;
    logic        mem_en1, mem_we1, mem_busy1, mem_done1;
    logic [31:0] mem_addr1, mem_din1, mem_dout1;
    logic [3:0]  mem_mask1;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] rd_last [2];
    int          lat0;
    logic        hang_release, inj_done;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .RR_EN(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr),
        .ifu_gnt_o(ifu_gnt), .ifu_done_o(ifu_done), .ifu_err_o(ifu_err), .ifu_rdata_o(ifu_rdata),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_mask_i(lsu_mask),
        .lsu_gnt_o(lsu_gnt), .lsu_done_o(lsu_done), .lsu_err_o(lsu_err), .lsu_rdata_o(lsu_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_din_o(mem_din), .mem_mask_o(mem_mask),
        .mem_dout_i(mem_dout), .mem_busy_i(mem_busy), .mem_done_i(mem_done)
    );

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .RR_EN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr),
        .ifu_gnt_o(ifu_gnt1), .ifu_done_o(ifu_done1), .ifu_err_o(ifu_err1), .ifu_rdata_o(ifu_rdata1),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_mask_i(lsu_mask),
        .lsu_gnt_o(lsu_gnt1), .lsu_done_o(lsu_done1), .lsu_err_o(lsu_err1), .lsu_rdata_o(lsu_rdata1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
        .mem_din_o(mem_din1), .mem_mask_o(mem_mask1),
        .mem_dout_i(mem_dout1), .mem_busy_i(mem_busy1), .mem_done_i(mem_done1)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // ---- adapter model for dut0: done appears lat0 cycles after mem_en;
    //      lat0 == 0 hangs busy until hang_release.
    logic [31:0] amem [16];
    logic        amem_init = 1'b0;
    int          a_cnt;
    logic        a_busy, a_done, a_we;
    logic [3:0]  a_idx, a_mask;
    logic [31:0] a_din, a_dout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt  <= 0;
            a_busy <= 1'b0;
            a_done <= 1'b0;
            if (!amem_init) begin
                for (int i = 0; i < 16; i++) amem[i] <= init_word(i);
                amem_init <= 1'b1;
            end
        end else begin
            a_done <= 1'b0;
            if (a_cnt != 0) begin
                a_cnt <= a_cnt - 1;
                if (a_cnt == 1) begin
                    a_busy <= 1'b0;
                    a_done <= 1'b1;
                    if (a_we) begin
                        for (int b = 0; b < 4; b++)
                            if (a_mask[b]) amem[a_idx][8*b +: 8] <= a_din[8*b +: 8];
                    end else begin
                        a_dout <= amem[a_idx];
                    end
                end
            end else if (mem_en) begin
                a_we   <= mem_we;
                a_idx  <= mem_addr[5:2];
                a_din  <= mem_din;
                a_mask <= mem_mask;
                a_busy <= 1'b1;
                if (lat0 >= 2) a_cnt <= lat0 - 1;
            end
            if (hang_release) a_busy <= 1'b0;
        end
    end

    assign mem_busy = a_busy;
    assign mem_done = a_done | inj_done;
    assign mem_dout = a_dout;

    // ---- adapter model for dut1: fixed 4-cycle access, data = addr^din^ctl
    logic [3:0]  sh1;
    logic [31:0] d1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh1 <= '0;
            d1  <= '0;
        end else begin
            sh1 <= {sh1[2:0], mem_en1};
            if (mem_en1) d1 <= mem_addr1 ^ mem_din1 ^ {27'd0, mem_we1, mem_mask1};
        end
    end
    assign mem_done1 = sh1[3];
    assign mem_busy1 = |sh1[2:0];
    assign mem_dout1 = d1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete access on dut0, started away from the clock edge.
    task automatic run_txn(input string tag, input bit port, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input int exp_lat, input bit exp_err);
        int          k;
        int          en_cnt;
        int          en_at;
        bit          w;
        logic [3:0]  idx;
        logic [31:0] exp_rd;
        w   = port && we;
        idx = addr[5:2];
        if (port) begin
            lsu_req = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata; lsu_mask = mask;
        end else begin
            ifu_req = 1'b1; ifu_addr = addr;
        end
        #1;
        check({tag, " gnt"},       port ? lsu_gnt : ifu_gnt, 1);
        check({tag, " other gnt"}, port ? ifu_gnt : lsu_gnt, 0);
        en_cnt = 0;
        en_at  = 0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ifu_req = 1'b0; lsu_req = 1'b0;
                lsu_we = ~we; lsu_addr = ~addr; lsu_wdata = ~wdata; lsu_mask = ~mask;
                ifu_addr = ~addr;
            end
            #1;
            if (mem_en) begin en_cnt++; en_at = k; end
            if ((port ? lsu_done : ifu_done) === 1'b1) break;
        end
        if (exp_err)  exp_rd = 32'h0;
        else if (w)   exp_rd = rd_last[port];
        else          exp_rd = ref_mem[idx];
        check({tag, " latency"},    k, exp_lat);
        check({tag, " err"},        port ? lsu_err : ifu_err, exp_err);
        check({tag, " rdata"},      port ? lsu_rdata : ifu_rdata, exp_rd);
        check({tag, " other done"}, port ? ifu_done : lsu_done, 0);
        check({tag, " en count"},   en_cnt, 1);
        check({tag, " en cycle"},   en_at, 1);
        check({tag, " mem_addr"},   mem_addr, addr);
        check({tag, " mem_we"},     mem_we, w);
        check({tag, " mem_mask"},   mem_mask, w ? mask : 4'h0);
        if (!port || w) check({tag, " mem_din"}, mem_din, port ? wdata : 32'h0);
        rd_last[port] = exp_rd;
        if (w && !exp_err)
            for (int b = 0; b < 4; b++)
                if (mask[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        @(negedge clk);
        #1;
        check({tag, " done pulse"}, port ? lsu_done : ifu_done, 0);
        check({tag, " err pulse"},  port ? lsu_err : ifu_err, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ifu_gnt"},   ifu_gnt, 0);
        check({tag, " lsu_gnt"},   lsu_gnt, 0);
        check({tag, " ifu_done"},  ifu_done, 0);
        check({tag, " lsu_done"},  lsu_done, 0);
        check({tag, " ifu_err"},   ifu_err, 0);
        check({tag, " lsu_err"},   lsu_err, 0);
        check({tag, " ifu_rdata"}, ifu_rdata, 0);
        check({tag, " lsu_rdata"}, lsu_rdata, 0);
        check({tag, " mem_en"},    mem_en, 0);
        check({tag, " mem_we"},    mem_we, 0);
        check({tag, " mem_addr"},  mem_addr, 0);
        check({tag, " mem_din"},   mem_din, 0);
        check({tag, " mem_mask"},  mem_mask, 0);
    endtask

    initial begin
        int gq[$];
        int l1g, i1g, l1d, i1d, e1;

        ifu_req = 0; lsu_req = 0; lsu_we = 0;
        ifu_addr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_mask = 0;
        lat0 = 4; hang_release = 0; inj_done = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        rd_last[0] = 0; rd_last[1] = 0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // IFU read, LSU masked write, LSU read-back
        run_txn("ifu_rd", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 6, 1'b0);
        run_txn("lsu_wr", 1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, 6, 1'b0);
        run_txn("lsu_rd", 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 6, 1'b0);

        // Hung adapter: timeout error, FLUSH blocks grants, late done dropped
        lat0 = 0;
        run_txn("hang", 1'b1, 1'b0, 32'h28, 32'h0, 4'h0, TO + 2, 1'b1);
        ifu_req = 1'b1; ifu_addr = 32'h4;
        #1;
        check("flush gnt", ifu_gnt, 0);
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        #1;
        check("late done ifu", ifu_done, 0);
        check("late done lsu", lsu_done, 0);
        check("late err lsu",  lsu_err, 0);
        check("flush gnt2",    ifu_gnt, 0);
        ifu_req = 1'b0;
        hang_release = 1'b1;
        @(negedge clk);
        hang_release = 1'b0;
        @(negedge clk);
        lat0 = 4;
        run_txn("post_flush", 1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 6, 1'b0);

        // done on the same cycle the watchdog expires
        lat0 = TO;
        run_txn("edge_done", 1'b0, 1'b0, 32'h18, 32'h0, 4'h0, TO + 2, 1'b0);

        // randomized single accesses
        for (int n = 0; n < 20; n++) begin
            bit          p, we;
            logic [31:0] a, d;
            logic [3:0]  m;
            int          l;
            p  = 1'($urandom_range(0, 1));
            we = p ? 1'($urandom_range(0, 1)) : 1'b0;
            a  = $urandom & 32'h0000_FFFC;
            d  = $urandom;
            m  = 4'($urandom_range(0, 15));
            l  = $urandom_range(2, 12);
            lat0 = l;
            run_txn($sformatf("rnd%0d", n), p, we, a, d, m, l + 2, 1'b0);
        end

        // asynchronous reset in the middle of WAIT
        lat0 = 4;
        ifu_req = 1'b1; ifu_addr = 32'h14;
        @(negedge clk);
        ifu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        lsu_req = 1'b1;
        #1;
        check_all_zero("mid_rst");
        lsu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_last[0] = 0; rd_last[1] = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("post_rst done %0d", c), {ifu_done, lsu_done, ifu_err, lsu_err}, 0);
        end

        // both ports requesting continuously
        l1g = 0; i1g = 0; l1d = 0; i1d = 0; e1 = 0;
        ifu_req = 1'b1; ifu_addr = 32'h10;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h24; lsu_wdata = 0; lsu_mask = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 24) begin ifu_req = 1'b0; lsu_req = 1'b0; end
            #1;
            if (ifu_gnt)   gq.push_back(c * 2);
            if (lsu_gnt)   gq.push_back(c * 2 + 1);
            if (ifu_gnt1)  i1g++;
            if (lsu_gnt1)  l1g++;
            if (ifu_done1) i1d++;
            if (lsu_done1) l1d++;
            if (ifu_err1 || lsu_err1) e1++;
            @(negedge clk);
        end
        check("rr grant count", gq.size(), 4);
        for (int n = 0; n < 4; n++)
            check($sformatf("rr grant %0d", n), (n < gq.size()) ? gq[n] : -1,
                  12 * n + (((n % 2) == 0) ? 1 : 0));
        check("rr ifu rdata", ifu_rdata, ref_mem[4]);
        check("rr lsu rdata", lsu_rdata, ref_mem[9]);
        check("fixed lsu grants", l1g, 4);
        check("fixed ifu grants", i1g, 0);
        check("fixed lsu dones",  l1d, 4);
        check("fixed ifu dones",  i1d, 0);
        check("fixed errs",       e1, 0);
        check("fixed lsu rdata",  lsu_rdata1, 32'h24);
        check("fixed ifu rdata",  ifu_rdata1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
